// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants and state encoding for the debug load engine
package debug_pkg;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;

    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam logic [ADDR_W-1:0] BASE_ADDR = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHK    = 3'd5
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs bytes LSB-first into 32-bit words and keeps a running XOR checksum
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [7:0]  checksum
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  chk_q, chk_d;

    // Lane insertion and checksum update; clr restarts a frame without touching the word lanes.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        chk_d  = chk_q;
        if (clr) begin
            idx_d = 2'd0;
            chk_d = 8'h00;
        end else if (byte_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            chk_d = chk_q ^ byte_in;
            idx_d = idx_q + 2'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
            chk_q  <= 8'h00;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            chk_q  <= chk_d;
        end
    end

    // The completed word is visible in the same cycle as its 4th byte so the loader can latch it.
    assign word       = word_d;
    assign word_ready = byte_valid && !clr && (idx_q == 2'd3);
    assign checksum   = chk_q;

endmodule

// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - framed byte-stream loader driving the program memory write port
module debug_loader
    import debug_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datain,
    output logic        mem_wr,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [ADDR_W:0]   words_left_q, words_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       datain_q, datain_d;
    logic              wr_q, wr_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              asm_clr;
    logic              asm_byte;
    logic [31:0]       asm_word;
    logic              asm_word_ready;
    logic [7:0]        asm_checksum;
    logic [15:0]       n_words;

    assign accept  = rx_valid && rx_ready_q;
    assign n_words = {rx_data, cnt_lo_q};

    word_assembler u_asm (
        .clk        (Clk),
        .rst        (Rst),
        .clr        (asm_clr),
        .byte_valid (asm_byte),
        .byte_in    (rx_data),
        .word       (asm_word),
        .word_ready (asm_word_ready),
        .checksum   (asm_checksum)
    );

    // Frame FSM: next state, address/word counters and all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        datain_d     = datain_q;
        wr_d         = 1'b0;
        hold_d       = hold_q;
        done_d       = done_q;
        err_d        = err_q;
        asm_clr      = 1'b0;
        asm_byte     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    asm_clr = 1'b1;
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = rx_data;
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    if (n_words > 16'(DEPTH)) begin
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end else if (n_words == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        words_left_d = n_words[ADDR_W:0];
                        addr_d       = BASE_ADDR;
                        state_d      = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_byte = 1'b1;
                    if (asm_word_ready) begin
                        datain_d = asm_word;
                        wr_d     = 1'b1;
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                // The last word leaves the address on the final location instead of stepping past it.
                words_left_d = words_left_q - ONE_WORD;
                if (words_left_q == ONE_WORD) begin
                    state_d = CHK;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = DATA;
                end
            end
            CHK: begin
                if (accept) begin
                    if (rx_data == asm_checksum) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rx_ready_d = (state_d != WRITE);
    end

    // Registers with synchronous reset; reset aborts any frame in progress.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            rx_ready_q   <= 1'b0;
            cnt_lo_q     <= 8'h00;
            words_left_q <= '0;
            addr_q       <= BASE_ADDR;
            datain_q     <= 32'h0;
            wr_q         <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            cnt_lo_q     <= cnt_lo_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            datain_q     <= datain_d;
            wr_q         <= wr_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_address = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign mem_datain  = datain_q;
    assign mem_wr      = wr_q;
    assign cpu_hold    = hold_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - self-checking bench for debug_loader
module tb_debug_loader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_wr;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    typedef struct {
        int n;
        int mode;
        bit bad;
        bit garb;
        bit gaps;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t tbl[8];

    debug_loader dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_address (mem_address),
        .mem_datain  (mem_datain),
        .mem_wr      (mem_wr),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst && mem_wr) begin
            got_addr.push_back(mem_address);
            got_data.push_back(mem_datain);
            check("rx_ready_in_write", {31'b0, rx_ready}, 32'd0);
            check("hold_in_write", {31'b0, cpu_hold}, 32'd1);
            check("addr_in_range", {31'b0, (mem_address < 32'd2048)}, 32'd1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        int guard;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                rx_valid = 1'b0;
                @(negedge Clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        check("handshake", {31'b0, rx_ready}, 32'd1);
        if (rx_ready) @(negedge Clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
        check({tag, "_addr"}, mem_address, 32'd0);
        check({tag, "_datain"}, mem_datain, 32'd0);
        check({tag, "_wr"}, {31'b0, mem_wr}, 32'd0);
        check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'b0, load_done}, 32'd0);
        check({tag, "_err"}, {31'b0, load_err}, 32'd0);
    endtask

    task automatic run_frame(input int n, input int mode, input bit bad, input bit garb,
                             input bit gaps, input bit exp_done, input bit exp_err, input string tag);
        logic [31:0] w[$];
        logic [7:0]  x;
        logic [7:0]  bb;
        logic [15:0] n16;
        int          exp_writes;
        int          mism;
        n16 = 16'(n);
        got_addr.delete();
        got_data.delete();
        w.delete();
        for (int i = 0; i < n && n <= 2048; i++) begin
            if (mode == 0) w.push_back((i == 0) ? 32'h11223344 : 32'hDEADBEEF);
            else if (mode == 1) w.push_back($urandom);
            else w.push_back(32'h1000_0000 + 32'(i));
        end
        if (garb) begin
            send_byte(8'h00, gaps);
            send_byte(8'hFF, gaps);
            send_byte(8'h5A, gaps);
            check({tag, "_garbage_no_hold"}, {31'b0, cpu_hold}, 32'd0);
        end
        send_byte(8'hA5, gaps);
        check({tag, "_sync_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({tag, "_sync_clr"}, {30'b0, load_done, load_err}, 32'd0);
        send_byte(n16[7:0], gaps);
        send_byte(n16[15:8], gaps);
        if (n <= 2048) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    bb = 8'(w[i] >> (8 * k));
                    x  = x ^ bb;
                    send_byte(bb, gaps);
                end
            end
            if (bad) x = ~x;
            send_byte(x, gaps);
        end
        check({tag, "_done"}, {31'b0, load_done}, {31'b0, exp_done});
        check({tag, "_err"}, {31'b0, load_err}, {31'b0, exp_err});
        check({tag, "_hold_released"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, "_idle_ready"}, {31'b0, rx_ready}, 32'd1);
        exp_writes = (n <= 2048) ? n : 0;
        check({tag, "_write_count"}, 32'(got_addr.size()), 32'(exp_writes));
        mism = 0;
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++) begin
            if (got_addr[i] !== 32'(i) || got_data[i] !== w[i]) mism++;
        end
        check({tag, "_write_contents"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int rn;
        bit rbad;
        tbl[0] = '{n: 2,    mode: 0, bad: 0, garb: 0, gaps: 0, exp_done: 1, exp_err: 0};
        tbl[1] = '{n: 2,    mode: 0, bad: 1, garb: 0, gaps: 0, exp_done: 0, exp_err: 1};
        tbl[2] = '{n: 2049, mode: 2, bad: 0, garb: 0, gaps: 0, exp_done: 0, exp_err: 1};
        tbl[3] = '{n: 2,    mode: 0, bad: 0, garb: 1, gaps: 1, exp_done: 1, exp_err: 0};
        tbl[4] = '{n: 0,    mode: 1, bad: 0, garb: 0, gaps: 0, exp_done: 1, exp_err: 0};
        tbl[5] = '{n: 5,    mode: 1, bad: 0, garb: 1, gaps: 1, exp_done: 1, exp_err: 0};
        tbl[6] = '{n: 3,    mode: 1, bad: 1, garb: 0, gaps: 1, exp_done: 0, exp_err: 1};
        tbl[7] = '{n: 2048, mode: 2, bad: 0, garb: 0, gaps: 0, exp_done: 1, exp_err: 0};

        Rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge Clk);
        check_reset_values("reset");
        Rst = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].n, tbl[i].mode, tbl[i].bad, tbl[i].garb, tbl[i].gaps,
                      tbl[i].exp_done, tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            rn   = ($urandom_range(0, 7) == 0) ? 2049 + $urandom_range(0, 300) : $urandom_range(0, 6);
            rbad = 1'($urandom_range(0, 1));
            run_frame(rn, 1, rbad, 1'($urandom_range(0, 1)), 1'b1,
                      (rn <= 2048) && !rbad, (rn > 2048) || rbad, $sformatf("rand%0d", i));
        end

        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        check("midframe_hold", {31'b0, cpu_hold}, 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_values("midreset");
        Rst = 1'b0;
        @(negedge Clk);
        run_frame(1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
